dice_roller: RTL and testbench
==============================

Name: dice_roller

Overview:
- Electronic dice for a TinyTapeout tile. Seven buttons select the die size: d4, d6, d8, d10, d12, d20 and d100.
- Holding a button spins a fast counter. Releasing it freezes the result.
- The result is shown on a two-digit multiplexed 7-segment display.
- Button, segment and digit-common polarities are selectable through uio_in pins, so one die can drive different boards.

Parameters:
- MUX_BITS, 10, width of the display-multiplex counter; its MSB selects the digit (units/tens). Benches use a small value, e.g. 4.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-high (asserted when 1).
- ena  in  1  tile enable; ignored, the design runs regardless.
- ui_in  in  8  buttons: [0]=d4, [1]=d6, [2]=d8, [3]=d10, [4]=d12, [5]=d20, [6]=d100; [7] unused.
- uio_in  in  8  config: [5]=button polarity (1 = active-high), [6]=segment polarity (1 = lit when 1), [7]=common polarity (common active when pin equals uio_in[7]); others unused.
- uo_out  out  8  segments: [0]=a … [6]=g, [7]=dp.
- uio_out  out  8  [0]=units-digit common, [1]=tens-digit common, [7:2]=0.
- uio_oe  out  8  constant 8'b0000_0011.

Behaviour:
- Button conditioning:
  - press = ui_in[i] XNOR uio_in[5]. A button reads "pressed" when ui_in[i] equals uio_in[5]; uio_in[5]=0 therefore means active-low buttons.
  - Each press goes through a 2-flop synchronizer; this adds 2 cycles of latency on both press and release.
- Die selection:
  - If several synced buttons are pressed, the lowest index wins (d4 has highest priority).
  - Sides N = 4, 6, 8, 10, 12, 20, 100.
- Rolling:
  - First cycle with any synced press while the previous cycle had none: value := 1 and die := selected N.
  - Each further cycle with the press still held: value := value+1, wrapping N→1.
  - If the selected die changes while held: value := 1 and the new N is latched.
  - On release, value holds indefinitely.
  - Net effect: a press held for k synced cycles leaves value = ((k-1) mod N)+1.
- value register is 7 bits; it is 0 only after reset. value 0 means a blank display.
- Digit decode:
  - units = value mod 10; tens = (value/10) mod 10.
  - 100 displays as "00" with tens shown.
  - Tens is blanked when value < 10.
  - Both digits are blanked when value = 0.
- Segment codes (gfedcba), dp always 0: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- Multiplex:
  - A free-running MUX_BITS counter; MSB=0 shows units, MSB=1 shows tens.
  - The active digit drives its common to uio_in[7]. The other common drives ~uio_in[7].
  - A blanked digit leaves both commons inactive and all segments unlit.
  - Physical segment pins = logical segments XNOR uio_in[6], i.e. lit when the pin equals uio_in[6]; unlit pins drive ~uio_in[6].
  - Polarity inputs apply combinationally, with no synchronizer.
  - Digit/segment outputs are registered, so common and segments change on the same clock edge and never glitch between digits.
- Reset (asynchronous):
  - Clears synchronizers, value (0, blank), die, and mux counter.
  - Outputs show blank: both commons inactive, all segments unlit per current polarity.
  - Reset asserted mid-roll aborts the roll; after release the display stays blank until the next press.

Decomposition:
- Shared package holds:
  - die-size constant array (4, 6, 8, 10, 12, 20, 100);
  - the 7-segment code table plus a BLANK code;
  - button index constants.
- One sub-module: seg7_decode (4-bit digit plus blank flag → 7 segments).

Test Plan:
- Reset with uio_in[7:5]=3'b111: no common equals 1 → display empty (all lit segments 0); uio_oe=0x03, uio_out[7:2]=0.
- Active-low buttons (uio_in[5]=0): hold d6 for 8 synced cycles then release → units digit shows 2, tens blank; value stays stable over 1000 cycles.
- d20 held 19 cycles → displays 19: tens "1" (0000110), units "9" (1101111), alternating per MUX_BITS MSB.
- d100 held 100 cycles → "00" on both digits. Held 101 cycles → units "1", tens blank.
- d4 and d12 pressed together for 6 cycles → d4 wins → shows 2. Releasing d4 while d12 is still held restarts at 1 and counts 1..12.
- Polarity sweep over all 8 uio_in[7:5] combinations with a fixed result of 7 → decoded digit is always 7 (0000111); toggling uio_in[6] only inverts uo_out.

Source files
------------

// File: rtl/dice_roller_pkg.sv
// Shared constants for the dice roller: die sizes, button indices and
// the gfedcba seven-segment table.
package dice_roller_pkg;

  typedef enum logic [2:0] {
    DIE_D4,
    DIE_D6,
    DIE_D8,
    DIE_D10,
    DIE_D12,
    DIE_D20,
    DIE_D100
  } die_e;

  localparam int NUM_BUTTONS = 7;
  localparam int BTN_D4      = 0;
  localparam int BTN_D100    = 6;

  localparam logic [6:0] DIE_SIDES [NUM_BUTTONS] = '{
    7'd4, 7'd6, 7'd8, 7'd10, 7'd12, 7'd20, 7'd100
  };

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] SEG_CODES [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };

endpackage

// File: rtl/dice_roller_if.sv
// TinyTapeout-style pin bundle for the dice roller tile.
interface dice_roller_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/dice_roller_seg7_decode.sv
// One decimal digit to logical gfedcba segments; blank forces all segments off.
module seg7_decode
  import dice_roller_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank && digit <= 4'd9) begin
      seg = SEG_CODES[digit];
    end
  end

endmodule

// File: rtl/dice_roller.sv
// Electronic dice: hold a button to spin, release to freeze; the result is
// shown on a two-digit multiplexed display with board-selectable polarities.
module dice_roller
  import dice_roller_pkg::*;
#(
  parameter int MUX_BITS = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  dice_roller_if.slave  bus
);

  logic [NUM_BUTTONS-1:0] press_raw;
  logic [NUM_BUTTONS-1:0] sync_a;
  logic [NUM_BUTTONS-1:0] sync_b;
  logic                   any_press;
  logic                   any_prev;
  die_e                   sel;
  die_e                   die;
  logic [6:0]             sides;
  logic [6:0]             value;

  logic [MUX_BITS-1:0]    mux_cnt;
  logic [3:0]             units;
  logic [3:0]             tens;
  logic                   units_blank;
  logic                   tens_blank;
  logic [6:0]             units_seg;
  logic [6:0]             tens_seg;
  logic [6:0]             seg_q;
  logic                   units_on_q;
  logic                   tens_on_q;
  logic                   unused_bits;

  // A button reads pressed when its pin matches the configured polarity.
  assign press_raw = ~(bus.ui_in[BTN_D100:BTN_D4] ^ {NUM_BUTTONS{bus.uio_in[5]}});

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= press_raw;
      sync_b <= sync_a;
    end
  end

  always_comb begin
    sel = DIE_D4;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (sync_b[i]) begin
        sel = die_e'(i[2:0]);
      end
    end
  end

  assign any_press = |sync_b;
  assign sides     = DIE_SIDES[sel];

  // A fresh press or a change of die restarts the count at 1.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      value    <= 7'd0;
      die      <= DIE_D4;
      any_prev <= 1'b0;
    end else begin
      any_prev <= any_press;
      if (any_press) begin
        if (!any_prev || sel != die) begin
          value <= 7'd1;
          die   <= sel;
        end else if (value >= sides) begin
          value <= 7'd1;
        end else begin
          value <= value + 7'd1;
        end
      end
    end
  end

  assign units       = 4'(value % 7'd10);
  assign tens        = 4'((value / 7'd10) % 7'd10);
  assign units_blank = (value == 7'd0);
  assign tens_blank  = (value < 7'd10);

  seg7_decode u_units (
    .digit (units),
    .blank (units_blank),
    .seg   (units_seg)
  );

  seg7_decode u_tens (
    .digit (tens),
    .blank (tens_blank),
    .seg   (tens_seg)
  );

  // Segments and commons are registered together so a digit switch is one clean edge.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      mux_cnt    <= '0;
      seg_q      <= SEG_BLANK;
      units_on_q <= 1'b0;
      tens_on_q  <= 1'b0;
    end else begin
      mux_cnt <= mux_cnt + MUX_BITS'(1);
      if (mux_cnt[MUX_BITS-1]) begin
        seg_q      <= tens_seg;
        units_on_q <= 1'b0;
        tens_on_q  <= !tens_blank;
      end else begin
        seg_q      <= units_seg;
        units_on_q <= !units_blank;
        tens_on_q  <= 1'b0;
      end
    end
  end

  assign bus.uo_out  = {~bus.uio_in[6], ~(seg_q ^ {7{bus.uio_in[6]}})};
  assign bus.uio_out = {6'b000000,
                        tens_on_q  ? bus.uio_in[7] : ~bus.uio_in[7],
                        units_on_q ? bus.uio_in[7] : ~bus.uio_in[7]};
  assign bus.uio_oe  = 8'b0000_0011;

  assign unused_bits = &{1'b0, bus.ena, bus.ui_in[7], bus.uio_in[4:0]};

endmodule

// File: tb/tb_dice_roller.sv
// Scoreboard bench for dice_roller: rolls are driven with a known hold time,
// the expected face is queued, then decoded back off the multiplexed pins.
module tb_dice_roller;

  localparam int MUX_BITS = 4;
  localparam int PERIOD   = 1 << MUX_BITS;

  typedef struct {
    string tag;
    int    value;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  dice_roller_if bus ();

  dice_roller #(.MUX_BITS(MUX_BITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t       scoreboard [$];
  int         total = 0;
  int         bad   = 0;
  logic [6:0] seg_ref [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  int         sides_ref [7] = '{4, 6, 8, 10, 12, 20, 100};

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Closed-form face after k held cycles on the highest-priority die in mask.
  function automatic int expValue(input logic [6:0] mask, input int k);
    int n = 1;
    for (int i = 6; i >= 0; i--) begin
      if (mask[i]) n = sides_ref[i];
    end
    return ((k - 1) % n) + 1;
  endfunction

  task automatic driveButtons(input logic [6:0] mask);
    for (int i = 0; i < 7; i++) begin
      bus.ui_in[i] = mask[i] ? bus.uio_in[5] : ~bus.uio_in[5];
    end
    bus.ui_in[7] = 1'b0;
  endtask

  task automatic pushExpected(input string tag, input int value);
    scoreboard.push_back(exp_t'{tag, value});
  endtask

  task automatic applyStimulus(input string tag, input logic [6:0] mask,
                               input int cycles, input bit release_after);
    driveButtons(mask);
    repeat (cycles) @(negedge clk);
    if (release_after) begin
      driveButtons(7'b0000000);
      pushExpected(tag, expValue(mask, cycles));
    end
  endtask

  task automatic checkDisplay();
    exp_t       e;
    int         units_cnt = 0;
    int         tens_cnt  = 0;
    int         units_seg = 0;
    int         tens_seg  = 0;
    int         stray     = 0;
    int         exp_units;
    int         exp_tens;
    logic [6:0] lit;
    logic       u_on;
    logic       t_on;
    if (scoreboard.size() == 0) begin
      checkOutput("scoreboard_empty", 1, 0);
      return;
    end
    e = scoreboard.pop_front();
    repeat (6) @(negedge clk);
    for (int c = 0; c < 2 * PERIOD; c++) begin
      @(negedge clk);
      lit  = ~(bus.uo_out[6:0] ^ {7{bus.uio_in[6]}});
      u_on = (bus.uio_out[0] == bus.uio_in[7]);
      t_on = (bus.uio_out[1] == bus.uio_in[7]);
      if (u_on && t_on) stray++;
      if (!u_on && !t_on && lit != 7'd0) stray++;
      if (bus.uo_out[7] != ~bus.uio_in[6]) stray++;
      if (bus.uio_out[7:2] != 6'd0 || bus.uio_oe != 8'h03) stray++;
      if (u_on) begin
        units_cnt++;
        units_seg = int'(lit);
      end
      if (t_on) begin
        tens_cnt++;
        tens_seg = int'(lit);
      end
    end
    exp_units = (e.value == 0) ? 0 : int'(seg_ref[e.value % 10]);
    exp_tens  = (e.value >= 10) ? int'(seg_ref[(e.value / 10) % 10]) : 0;
    checkOutput({e.tag, ".units_seg"}, units_seg, exp_units);
    checkOutput({e.tag, ".tens_seg"},  tens_seg,  exp_tens);
    checkOutput({e.tag, ".units_cnt"}, units_cnt, (e.value == 0) ? 0 : PERIOD);
    checkOutput({e.tag, ".tens_cnt"},  tens_cnt,  (e.value >= 10) ? PERIOD : 0);
    checkOutput({e.tag, ".stray"},     stray,     0);
  endtask

  initial begin
    logic [7:0] prev_uo;
    logic [7:0] prev_uio;
    logic [7:0] want;

    bus.ena    = 1'b1;
    bus.uio_in = 8'hE0;
    bus.ui_in  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset.uo_out",  int'(bus.uo_out),  0);
    checkOutput("reset.uio_out", int'(bus.uio_out), 0);
    checkOutput("reset.uio_oe",  int'(bus.uio_oe),  3);
    rst_n = 1'b0;
    pushExpected("post_reset", 0);
    checkDisplay();

    // Active-low buttons, active-high segments and commons.
    bus.uio_in = 8'hC0;
    driveButtons(7'b0000000);
    repeat (4) @(negedge clk);
    applyStimulus("d6_8", 7'b0000010, 8, 1'b1);
    checkDisplay();
    repeat (1000) @(negedge clk);
    pushExpected("d6_hold", 2);
    checkDisplay();

    applyStimulus("d20_19", 7'b0100000, 19, 1'b1);
    checkDisplay();
    applyStimulus("d100_100", 7'b1000000, 100, 1'b1);
    checkDisplay();
    applyStimulus("d100_101", 7'b1000000, 101, 1'b1);
    checkDisplay();

    applyStimulus("d4d12_6", 7'b0010001, 6, 1'b1);
    checkDisplay();
    applyStimulus("d4d12_pre", 7'b0010001, 6, 1'b0);
    applyStimulus("d12_restart", 7'b0010000, 12, 1'b1);
    checkDisplay();

    // Reset in the middle of a roll leaves the display blank.
    applyStimulus("d10_pre", 7'b0001000, 5, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    driveButtons(7'b0000000);
    want = {6'b000000, ~bus.uio_in[7], ~bus.uio_in[7]};
    checkOutput("midreset.commons", int'(bus.uio_out), int'(want));
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    pushExpected("midreset", 0);
    checkDisplay();

    bus.uio_in = 8'hE0;
    driveButtons(7'b0000000);
    repeat (4) @(negedge clk);
    applyStimulus("d8_7", 7'b0000100, 7, 1'b1);
    checkDisplay();

    for (int p = 0; p < 8; p++) begin
      bus.uio_in[7:5] = 3'(p);
      driveButtons(7'b0000000);
      pushExpected($sformatf("pol%0d", p), 7);
      checkDisplay();
      prev_uo  = bus.uo_out;
      prev_uio = bus.uio_out;
      bus.uio_in[6] = ~bus.uio_in[6];
      #1;
      want = ~prev_uo;
      checkOutput($sformatf("pol%0d.uo_inv", p), int'(bus.uo_out), int'(want));
      checkOutput($sformatf("pol%0d.uio_keep", p), int'(bus.uio_out), int'(prev_uio));
      bus.uio_in[6] = ~bus.uio_in[6];
      #1;
    end

    checkOutput("scoreboard_left", scoreboard.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
